// File: rtl/rename_release_controller_if.sv
// Bus between the active list / recovery logic and the rename release controller.
// The master side owns the active-list head/tail and the recovery trigger; the
// slave side is the controller that decides pops and drives the release stage.
interface rename_release_controller_if #(
    parameter int COMMIT_WIDTH = 2,
    parameter int AL_DEPTH     = 64,
    parameter int PREG_W       = 7,
    parameter int REG_CLASSES  = 2
);
    localparam int CNT_W  = $clog2(AL_DEPTH + 1);
    localparam int LANE_W = $clog2(COMMIT_WIDTH + 1);
    localparam int CLS_W  = (REG_CLASSES > 1) ? $clog2(REG_CLASSES) : 1;

    // Commit side
    logic                                             commit;
    logic [LANE_W-1:0]                                commit_num;

    // Per-lane view of the active-list entries being popped
    logic [COMMIT_WIDTH-1:0]                          al_write_reg;
    logic [COMMIT_WIDTH-1:0][CLS_W-1:0]               al_reg_class;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0]              al_prev_preg;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0]              al_dst_preg;
    logic [CNT_W-1:0]                                 al_recovery_entry_num;
    logic [LANE_W-1:0]                                al_pop_head_num;
    logic [LANE_W-1:0]                                al_pop_tail_num;

    // Recovery control
    logic                                             to_recovery;
    logic                                             recovery_from_rrmt;
    logic                                             in_recovery;
    logic                                             recovery_done;
    logic [LANE_W-1:0]                                flush_num;

    // Registered release stage towards the per-class free lists
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0]         release_valid;
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0][PREG_W-1:0] release_preg;

    modport master (
        output commit, commit_num,
        output al_write_reg, al_reg_class, al_prev_preg, al_dst_preg,
        output al_recovery_entry_num,
        output to_recovery, recovery_from_rrmt,
        input  al_pop_head_num, al_pop_tail_num,
        input  in_recovery, recovery_done, flush_num,
        input  release_valid, release_preg
    );

    modport slave (
        input  commit, commit_num,
        input  al_write_reg, al_reg_class, al_prev_preg, al_dst_preg,
        input  al_recovery_entry_num,
        input  to_recovery, recovery_from_rrmt,
        output al_pop_head_num, al_pop_tail_num,
        output in_recovery, recovery_done, flush_num,
        output release_valid, release_preg
    );
endinterface

// File: rtl/rename_release_controller.sv
// Rename-stage commit/recovery controller. In COMMIT it pops committed ops from
// the active-list head and frees their previous pregs; on recovery it walks the
// squashed entries (from head or tail) and frees their destination pregs.
// Freed pregs are routed to their class free list through one register stage.
module rename_release_controller #(
    parameter int COMMIT_WIDTH = 2,
    parameter int AL_DEPTH     = 64,
    parameter int PREG_W       = 7,
    parameter int REG_CLASSES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    rename_release_controller_if.slave al_bus
);
    localparam int CNT_W  = $clog2(AL_DEPTH + 1);
    localparam int LANE_W = $clog2(COMMIT_WIDTH + 1);

    localparam logic [LANE_W-1:0] CW_L = LANE_W'(COMMIT_WIDTH);

    localparam logic [1:0] PH_COMMIT       = 2'd0;
    localparam logic [1:0] PH_RECOVER_0    = 2'd1;
    localparam logic [1:0] PH_RECOVER_WALK = 2'd2;

    logic [1:0]                                        r_phase;
    logic [CNT_W-1:0]                                  r_rcount;
    logic                                              r_mode;
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0]          r_rel_valid;
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0][PREG_W-1:0] r_rel_preg;

    logic [LANE_W-1:0]                                 w_commit_k;
    logic [LANE_W-1:0]                                 w_walk_n;
    logic [LANE_W-1:0]                                 w_rel_cnt;
    logic                                              w_use_dst;
    logic [LANE_W-1:0]                                 w_pop_head;
    logic [LANE_W-1:0]                                 w_pop_tail;
    logic [LANE_W-1:0]                                 w_flush;
    logic                                              w_done;
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0]          w_rel_valid;
    logic [REG_CLASSES-1:0][COMMIT_WIDTH-1:0][PREG_W-1:0] w_rel_preg;

    // Lane counts: clamped commit count and the walk step (never past rcount).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_commit_k = '0;
        if (al_bus.commit) begin
            w_commit_k = (int'(al_bus.commit_num) > COMMIT_WIDTH) ? CW_L : al_bus.commit_num;
        end
        w_walk_n = (int'(r_rcount) > COMMIT_WIDTH) ? CW_L : LANE_W'(r_rcount);
    end

    // Per-phase pop/flush decode and choice of which preg each lane frees.
    always_comb begin
        w_pop_head = '0;
        w_pop_tail = '0;
        w_flush    = '0;
        w_done     = 1'b0;
        w_rel_cnt  = '0;
        w_use_dst  = 1'b0;
        case (r_phase)
            PH_COMMIT: begin
                w_pop_head = w_commit_k;
                w_rel_cnt  = w_commit_k;
            end
            PH_RECOVER_WALK: begin
                w_flush   = w_walk_n;
                w_rel_cnt = w_walk_n;
                w_use_dst = 1'b1;
                w_done    = (r_rcount == '0);
                if (r_mode) begin
                    w_pop_head = w_walk_n;
                end else begin
                    w_pop_tail = w_walk_n;
                end
            end
            default: begin
                // RECOVER_0 idles while the squashed-entry count is loaded.
            end
        endcase
    end

    // Route each active lane to the free list of its register class.
    always_comb begin
        w_rel_valid = '0;
        w_rel_preg  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if ((int'(w_rel_cnt) > i) && al_bus.al_write_reg[i]) begin
                for (int c = 0; c < REG_CLASSES; c++) begin
                    // Classes beyond REG_CLASSES match no c and are dropped.
                    if (int'(al_bus.al_reg_class[i]) == c) begin
                        w_rel_valid[c][i] = 1'b1;
                        w_rel_preg[c][i]  = w_use_dst ? al_bus.al_dst_preg[i]
                                                      : al_bus.al_prev_preg[i];
                    end
                end
            end
        end
    end

    // Phase sequencing; a recovery request always wins and restarts the walk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_phase  <= PH_COMMIT;
            r_rcount <= '0;
            r_mode   <= 1'b0;
        end else if (al_bus.to_recovery) begin
            r_phase  <= PH_RECOVER_0;
            r_rcount <= '0;
            r_mode   <= al_bus.recovery_from_rrmt;
        end else begin
            case (r_phase)
                PH_RECOVER_0: begin
                    r_phase  <= PH_RECOVER_WALK;
                    r_rcount <= al_bus.al_recovery_entry_num;
                end
                PH_RECOVER_WALK: begin
                    if (r_rcount == '0) begin
                        r_phase <= PH_COMMIT;
                    end else begin
                        r_rcount <= r_rcount - CNT_W'(w_walk_n);
                    end
                end
                default: r_phase <= PH_COMMIT;
            endcase
        end
    end

    // Release stage: one cycle after the pop; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rel_valid <= '0;
            r_rel_preg  <= '0;
        end else begin
            r_rel_valid <= w_rel_valid;
            r_rel_preg  <= w_rel_preg;
        end
    end

    assign al_bus.al_pop_head_num = w_pop_head;
    assign al_bus.al_pop_tail_num = w_pop_tail;
    assign al_bus.flush_num       = w_flush;
    assign al_bus.recovery_done   = w_done;
    assign al_bus.in_recovery     = (r_phase == PH_RECOVER_0) || (r_phase == PH_RECOVER_WALK);
    assign al_bus.release_valid   = r_rel_valid;
    assign al_bus.release_preg    = r_rel_preg;

endmodule

// File: tb/tb_rename_release_controller.sv
// Directed plus randomized bench for rename_release_controller. The reference
// model tracks recovery as "in recovery / count loaded / entries remaining"
// and derives pops and releases from those with plain integer arithmetic.
module tb_rename_release_controller;
    localparam int CW       = 2;
    localparam int AL_DEPTH = 64;
    localparam int PREG_W   = 7;
    localparam int RC       = 2;
    localparam int CNT_W    = $clog2(AL_DEPTH + 1);
    localparam int LANE_W   = $clog2(CW + 1);
    localparam int CLS_W    = (RC > 1) ? $clog2(RC) : 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rename_release_controller_if #(
        .COMMIT_WIDTH(CW), .AL_DEPTH(AL_DEPTH), .PREG_W(PREG_W), .REG_CLASSES(RC)
    ) bus ();

    rename_release_controller #(
        .COMMIT_WIDTH(CW), .AL_DEPTH(AL_DEPTH), .PREG_W(PREG_W), .REG_CLASSES(RC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .al_bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_in_rec;
    bit m_loaded;
    bit m_mode;
    int m_rem;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input bit w, input int cls, input int prev, input int dst);
        bus.al_write_reg[i] = w;
        bus.al_reg_class[i] = CLS_W'(cls);
        bus.al_prev_preg[i] = PREG_W'(prev);
        bus.al_dst_preg[i]  = PREG_W'(dst);
    endtask

    task automatic idle_inputs();
        rst                       = 1'b0;
        bus.commit                = 1'b0;
        bus.commit_num            = '0;
        bus.to_recovery           = 1'b0;
        bus.recovery_from_rrmt    = 1'b0;
        bus.al_recovery_entry_num = '0;
        for (int i = 0; i < CW; i++) set_lane(i, 1'b0, 0, 0, 0);
    endtask

    // One clock cycle: check same-cycle outputs, clock, check release stage, advance model.
    task automatic step(input string tag);
        int e_head, e_tail, e_flush, e_cnt;
        bit e_done, e_dst;
        logic [RC-1:0][CW-1:0]             nv;
        logic [RC-1:0][CW-1:0][PREG_W-1:0] np;
        e_head = 0; e_tail = 0; e_flush = 0; e_cnt = 0; e_done = 0; e_dst = 0;
        nv = '0; np = '0;
        #1;
        if (!m_in_rec) begin
            e_head = bus.commit ? ((int'(bus.commit_num) > CW) ? CW : int'(bus.commit_num)) : 0;
            e_cnt  = e_head;
        end else if (m_loaded) begin
            e_flush = (m_rem > CW) ? CW : m_rem;
            e_cnt   = e_flush;
            e_dst   = 1'b1;
            e_done  = (m_rem == 0);
            if (m_mode) e_head = e_flush; else e_tail = e_flush;
        end
        check({tag, ".pop_head"},    64'(bus.al_pop_head_num), 64'(e_head));
        check({tag, ".pop_tail"},    64'(bus.al_pop_tail_num), 64'(e_tail));
        check({tag, ".flush"},       64'(bus.flush_num),       64'(e_flush));
        check({tag, ".in_recovery"}, 64'(bus.in_recovery),     64'(m_in_rec));
        check({tag, ".done"},        64'(bus.recovery_done),   64'(e_done));
        for (int i = 0; i < e_cnt; i++) begin
            if (bus.al_write_reg[i] && int'(bus.al_reg_class[i]) < RC) begin
                nv[bus.al_reg_class[i]][i] = 1'b1;
                np[bus.al_reg_class[i]][i] = e_dst ? bus.al_dst_preg[i] : bus.al_prev_preg[i];
            end
        end
        if (rst) begin
            nv = '0;
            np = '0;
        end
        @(posedge clk);
        #1;
        check({tag, ".rel_valid"}, 64'(bus.release_valid), 64'(nv));
        check({tag, ".rel_preg"},  64'(bus.release_preg),  64'(np));
        if (rst) begin
            m_in_rec = 0; m_loaded = 0; m_mode = 0; m_rem = 0;
        end else if (bus.to_recovery) begin
            m_in_rec = 1; m_loaded = 0; m_mode = bus.recovery_from_rrmt;
        end else if (m_in_rec && !m_loaded) begin
            m_loaded = 1;
            m_rem    = int'(bus.al_recovery_entry_num);
        end else if (m_in_rec) begin
            if (m_rem == 0) m_in_rec = 0;
            else m_rem = m_rem - ((m_rem > CW) ? CW : m_rem);
        end
    endtask

    task automatic start_recovery(input bit from_head, input int entries);
        bus.to_recovery           = 1'b1;
        bus.recovery_from_rrmt    = from_head;
        bus.al_recovery_entry_num = CNT_W'(entries);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_in_rec = 0; m_loaded = 0; m_mode = 0; m_rem = 0;

        // Reset state held for one more cycle
        step("reset");
        check("reset.phase_idle", 64'(bus.in_recovery), 64'(0));
        rst = 1'b0;

        // Two-lane commit across both classes
        bus.commit = 1'b1; bus.commit_num = 2'd2;
        set_lane(0, 1'b1, 0, 5, 40);
        set_lane(1, 1'b1, 1, 9, 41);
        step("commit2");
        check("commit2.v00", 64'(bus.release_valid[0][0]), 64'(1));
        check("commit2.p00", 64'(bus.release_preg[0][0]),  64'(5));
        check("commit2.v11", 64'(bus.release_valid[1][1]), 64'(1));
        check("commit2.p11", 64'(bus.release_preg[1][1]),  64'(9));

        // Clamp of commit_num and a non-writing lane
        bus.commit_num = 2'd3;
        set_lane(1, 1'b0, 1, 12, 42);
        step("clamp");

        // Commit ignored when commit=0
        bus.commit = 1'b0;
        step("nocommit");

        // Tail walk of 5 entries, triggered together with a commit
        bus.commit = 1'b1; bus.commit_num = 2'd2;
        set_lane(0, 1'b1, 1, 3, 20);
        set_lane(1, 1'b1, 0, 4, 21);
        start_recovery(1'b0, 5);
        step("tailwalk.trigger");
        bus.to_recovery = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_lane(0, 1'b1, c % 2, 10 + c, 30 + c);
            set_lane(1, 1'b1, (c + 1) % 2, 50 + c, 70 + c);
            step("tailwalk");
        end
        check("tailwalk.back_in_commit", 64'(bus.in_recovery), 64'(0));

        // Head walk of 5 entries
        start_recovery(1'b1, 5);
        step("headwalk.trigger");
        bus.to_recovery = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_lane(0, c[0], 0, 60 + c, 90 + c);
            set_lane(1, 1'b1, 1, 61 + c, 100 + c);
            step("headwalk");
        end

        // Restart: walk of 7, re-triggered once rcount reaches 3
        start_recovery(1'b0, 7);
        step("restart.trigger");
        bus.to_recovery = 1'b0;
        step("restart.r0");
        step("restart.walk7");
        step("restart.walk5");
        check("restart.rem3", 64'(m_rem), 64'(3));
        start_recovery(1'b1, 4);
        step("restart.retrigger");
        bus.to_recovery = 1'b0;
        for (int c = 0; c < 5; c++) step("restart.walk2");
        check("restart.done_commit", 64'(bus.in_recovery), 64'(0));

        // Reset in the middle of a walk
        start_recovery(1'b0, 9);
        step("rstwalk.trigger");
        bus.to_recovery = 1'b0;
        step("rstwalk.r0");
        step("rstwalk.walk");
        rst = 1'b1;
        step("rstwalk.reset");
        rst = 1'b0;
        check("rstwalk.in_rec",  64'(bus.in_recovery),   64'(0));
        check("rstwalk.valid0",  64'(bus.release_valid), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst                       = ($urandom_range(0, 96) == 0);
            bus.commit                = $urandom_range(0, 1);
            bus.commit_num            = LANE_W'($urandom_range(0, 3));
            bus.to_recovery           = ($urandom_range(0, 24) == 0);
            bus.recovery_from_rrmt    = $urandom_range(0, 1);
            bus.al_recovery_entry_num = CNT_W'($urandom_range(0, AL_DEPTH));
            for (int i = 0; i < CW; i++) begin
                set_lane(i, $urandom_range(0, 1), $urandom_range(0, RC - 1),
                         $urandom_range(0, (1 << PREG_W) - 1), $urandom_range(0, (1 << PREG_W) - 1));
            end
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
